// File: rtl/sha256_pkg.sv
// sha256_pkg: shared constants, types and helper functions for the SHA-256
// message-schedule block.
//   SHA_WORD_W / ROUNDS / BLK_WORDS : word width, words emitted, words loaded
//   sched_state_e                   : LOAD (collect 16 words) / EMIT (stream W[t])
//   sig0_small / sig1_small         : small sigma functions of the schedule
//   byteswap32                      : byte reversal used by the optional
//                                     SHA256_SCHED_BYTESWAP_EN build
package sha256_pkg;

    localparam int SHA_WORD_W = 32;
    localparam int ROUNDS     = 64;
    localparam int BLK_WORDS  = 16;

    localparam int SIG0_ROT_A = 7;
    localparam int SIG0_ROT_B = 18;
    localparam int SIG0_SHR   = 3;
    localparam int SIG1_ROT_A = 17;
    localparam int SIG1_ROT_B = 19;
    localparam int SIG1_SHR   = 10;

    typedef logic [SHA_WORD_W-1:0] word_t;

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        EMIT = 1'b1
    } sched_state_e;

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (SHA_WORD_W - n));
    endfunction

    function automatic word_t sig0_small(input word_t x);
        return rotr(x, SIG0_ROT_A) ^ rotr(x, SIG0_ROT_B) ^ (x >> SIG0_SHR);
    endfunction

    function automatic word_t sig1_small(input word_t x);
        return rotr(x, SIG1_ROT_A) ^ rotr(x, SIG1_ROT_B) ^ (x >> SIG1_SHR);
    endfunction

    function automatic word_t byteswap32(input word_t x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

endpackage

// File: rtl/sha256_msg_schedule_if.sv
// sha256_msg_schedule_if: input word stream plus round-word output stream.
//   in_valid/in_ready/in_word          : 16 message words per block
//   out_valid/out_ready/out_word/
//   out_idx/out_last                   : schedule words W[0..63]
//   busy                               : block in progress
// Handshake rule for both streams: a word transfers on a rising clk edge
// where valid && ready are both high; the producer holds its data stable
// while valid is high and ready is low, and valid never depends on ready.
// slave  = the schedule generator, master = its environment.
interface sha256_msg_schedule_if;
    import sha256_pkg::*;

    logic        in_valid;
    logic        in_ready;
    word_t       in_word;
    logic        out_valid;
    logic        out_ready;
    word_t       out_word;
    logic [5:0]  out_idx;
    logic        out_last;
    logic        busy;

    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, out_word, out_idx, out_last, busy
    );

    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_word, out_idx, out_last, busy
    );
endinterface

// File: rtl/sha256_sched_sigma.sv
// sha256_sched_sigma: combinational next-schedule-word generator.
//   w0_i, w1_i, w9_i, w14_i : window taps W[t], W[t+1], W[t+9], W[t+14]
//   next_o                  : W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t] mod 2^32
// Kept separate so the adder tree can be retimed on its own.
module sha256_sched_sigma
    import sha256_pkg::*;
(
    input  word_t w0_i,
    input  word_t w1_i,
    input  word_t w9_i,
    input  word_t w14_i,
    output word_t next_o
);
    assign next_o = sig1_small(w14_i) + w9_i + sig0_small(w1_i) + w0_i;
endmodule

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule: SHA-256 message schedule generator.
//   clk      : clock
//   rst_n    : synchronous active-low reset
//   bus      : slave modport of sha256_msg_schedule_if (input words in,
//              schedule words W[0..63] out, busy)
//   state_o  : current FSM state (LOAD/EMIT), for debug/checkers
// Build option: define SHA256_SCHED_BYTESWAP_EN to byte-reverse each input
// word before storage (little-endian header words); ports/timing unchanged.
//
// A 16-word sliding window holds W[t..t+15]; win[0] drives out_word directly,
// so the output is fully registered.
module sha256_msg_schedule
    import sha256_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    sha256_msg_schedule_if.slave     bus,
    output sched_state_e             state_o
);
    sched_state_e state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [5:0]   t_q, t_d;
    word_t        win_q [BLK_WORDS];
    word_t        win_d [BLK_WORDS];
    word_t        in_word_st;
    word_t        next_w;
    logic         accept;
    logic         advance;

`ifdef SHA256_SCHED_BYTESWAP_EN
    assign in_word_st = byteswap32(bus.in_word);
`else
    assign in_word_st = bus.in_word;
`endif

    sha256_sched_sigma u_sigma (
        .w0_i   (win_q[0]),
        .w1_i   (win_q[1]),
        .w9_i   (win_q[9]),
        .w14_i  (win_q[14]),
        .next_o (next_w)
    );

    // in_ready is high for the whole of LOAD, out_valid for the whole of EMIT.
    assign accept  = (state_q == LOAD) && bus.in_valid;
    assign advance = (state_q == EMIT) && bus.out_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        t_d     = t_q;
        win_d   = win_q;
        if (accept) begin
            win_d[cnt_q] = in_word_st;
            cnt_d        = cnt_q + 4'd1;   // wraps to 0 on the 16th word
            if (cnt_q == 4'(BLK_WORDS - 1)) begin
                state_d = EMIT;
                t_d     = '0;
            end
        end
        if (advance) begin
            for (int i = 0; i < BLK_WORDS - 1; i++) begin
                win_d[i] = win_q[i+1];
            end
            // Words computed past W[63] are never presented.
            win_d[BLK_WORDS-1] = next_w;
            t_d                = t_q + 6'd1;
            if (t_q == 6'(ROUNDS - 1)) begin
                state_d = LOAD;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            t_q     <= '0;
            for (int i = 0; i < BLK_WORDS; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
            win_q   <= win_d;
        end
    end

    assign bus.in_ready  = (state_q == LOAD);
    assign bus.out_valid = (state_q == EMIT);
    assign bus.out_word  = win_q[0];
    assign bus.out_idx   = t_q;
    assign bus.out_last  = (state_q == EMIT) && (t_q == 6'(ROUNDS - 1));
    // A block is in progress once any word is held or while emitting.
    assign bus.busy      = (state_q == EMIT) || (cnt_q != 4'd0);
    assign state_o       = state_q;
endmodule
